// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    // Controller FSM states
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } hz_state_t;

    // Architectural zero register: writing it never creates a dependency
    localparam logic [4:0] XZR_IDX = 5'd31;

    // Per-stage advance/squash controls, packed in pipeline order
    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic ifid_flush;
        logic idex_we;
        logic idex_bubble;
        logic exmem_we;
        logic memwb_we;
    } stage_ctrl_t;

    // Canned control patterns for each pipeline action
    localparam stage_ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    localparam stage_ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam stage_ctrl_t CTRL_FLUSH  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam stage_ctrl_t CTRL_LU     = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline-side bundle: hazard inputs from ID/EX/MEM/WB and the stage controls back.
// Memory handshake: an access is outstanding in any cycle with dmem_req=1 and
// completes in the cycle where dmem_ready=1 is seen with it; dmem_ready
// without an outstanding request is ignored.
interface hazard_controller_if;
    logic [4:0] Rn_ID;
    logic [4:0] SrcB_ID;
    logic       UseA_ID;
    logic       UseB_ID;
    logic [4:0] Rd_EX;
    logic       MemRead_EX;
    logic       BrTaken_EX;
    logic       dmem_req;
    logic       dmem_ready;
    logic       Halt_WB;
    logic       pc_we;
    logic       ifid_we;
    logic       ifid_flush;
    logic       idex_we;
    logic       idex_bubble;
    logic       exmem_we;
    logic       memwb_we;

    // Controller side
    modport slave (
        input  Rn_ID, SrcB_ID, UseA_ID, UseB_ID, Rd_EX, MemRead_EX,
        input  BrTaken_EX, dmem_req, dmem_ready, Halt_WB,
        output pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_we
    );

    // Pipeline side
    modport master (
        output Rn_ID, SrcB_ID, UseA_ID, UseB_ID, Rd_EX, MemRead_EX,
        output BrTaken_EX, dmem_req, dmem_ready, Halt_WB,
        input  pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_we, memwb_we
    );
endinterface

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Increment on each event until the counter is full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: decides when each stage advances, flushes or bubbles.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int         CNT_W = 16,
    parameter logic [4:0] XZR   = XZR_IDX
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hazard_controller_if.slave   bus,
    output logic                 halted,
    output logic [CNT_W-1:0]     stall_count,
    output logic [CNT_W-1:0]     flush_count,
    output hz_state_t            state
);

    hz_state_t   next_state;
    stage_ctrl_t ctrl;
    logic        lu;
    logic        frozen;
    logic        stall_inc;

    // Load in EX feeding a live source of the ID instruction (XZR never aliases)
    assign lu = bus.MemRead_EX && (bus.Rd_EX != XZR) &&
                ((bus.UseA_ID && (bus.Rn_ID == bus.Rd_EX)) ||
                 (bus.UseB_ID && (bus.SrcB_ID == bus.Rd_EX)));

    // Whole pipeline holds while an access is outstanding; the completing
    // cycle in MEM_WAIT is also held so the data lands before anything moves
    assign frozen = ((state == RUN) && bus.dmem_req && !bus.dmem_ready) ||
                    (state == MEM_WAIT);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode: halt wins in RUN, MEM_WAIT ignores halt until it returns
    always_comb begin
        next_state = state;
        case (state)
            RUN: begin
                if (bus.Halt_WB) begin
                    next_state = HALT;
                end else if (bus.dmem_req && !bus.dmem_ready) begin
                    next_state = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (bus.dmem_ready) begin
                    next_state = RUN;
                end
            end
            HALT:    next_state = HALT;
            default: next_state = RUN;
        endcase
    end

    // Output decode in priority order: halt, freeze, branch flush, load-use bubble
    always_comb begin
        ctrl = CTRL_RUN;
        if (!rst_n) begin
            ctrl = CTRL_RUN;
        end else if (state == HALT) begin
            ctrl = CTRL_FREEZE;
        end else if (frozen) begin
            ctrl = CTRL_FREEZE;
        end else if (bus.BrTaken_EX) begin
            ctrl = CTRL_FLUSH;
        end else if (lu) begin
            ctrl = CTRL_LU;
        end
    end

    assign bus.pc_we       = ctrl.pc_we;
    assign bus.ifid_we     = ctrl.ifid_we;
    assign bus.ifid_flush  = ctrl.ifid_flush;
    assign bus.idex_we     = ctrl.idex_we;
    assign bus.idex_bubble = ctrl.idex_bubble;
    assign bus.exmem_we    = ctrl.exmem_we;
    assign bus.memwb_we    = ctrl.memwb_we;
    assign halted          = (state == HALT);

    // A halted core is not stalling, so it is excluded from the stall count
    assign stall_inc = !ctrl.pc_we && (state != HALT);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_inc),
        .count (stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ctrl.ifid_flush),
        .count (flush_count)
    );

endmodule
